// File: rtl/resp_que_drain.sv
// resp_que_drain: read side of the 8-slot response collector queue.
// Slots are filled out of order (real pushes at an upstream-chosen slot, multicast
// fake presets by mask) and drained strictly in ring order from rd_ptr. Real heads
// leave through a valid/ready port; fake heads retire silently, one per cycle.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   fake_set_vld, fake_set_mask   mark masked free slots occupied+fake
//   push_vld, push_ptr, push_data real response write into slot push_ptr
//   resp_array                    live occupancy (real or fake)
//   rd_ptr                        head slot index
//   out_vld, out_data, out_ready  head real response, valid/ready handshake
//   occ_cnt, que_empty, que_full  occupancy summaries
//   err_collide                   sticky: a write hit an occupied slot
module resp_que_drain #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fake_set_vld,
    input  logic [7:0]        fake_set_mask,
    input  logic              push_vld,
    input  logic [2:0]        push_ptr,
    input  logic [DATA_W-1:0] push_data,
    output logic [7:0]        resp_array,
    output logic [2:0]        rd_ptr,
    output logic              out_vld,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [3:0]        occ_cnt,
    output logic              que_empty,
    output logic              que_full,
    output logic              err_collide
);

    localparam int unsigned PTR_W = 3;
    localparam int unsigned CNT_W = 4;

    // Pointer and mask widths are hard-wired to 8 slots.
    if (DEPTH != 8) begin : g_bad_depth
        $error("resp_que_drain: DEPTH must be 8");
    end

    logic [7:0]        occ_q, occ_nxt;
    logic [7:0]        fake_q, fake_nxt;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_nxt;
    logic              err_q, err_nxt;
    logic [DATA_W-1:0] data_q [8];

    logic              retire;
    logic              push_ok;
    logic              push_hit;
    logic              fake_hit;
    logic [7:0]        push_oh;
    logic [7:0]        fake_ok;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              vld_nxt;
    logic [DATA_W-1:0] odata_nxt;

    // Writes are judged against pre-edge occupancy, so a slot retiring this cycle
    // still counts as taken and any write to it is a collision.
    always_comb begin
        retire     = occ_q[rd_ptr_q] & (fake_q[rd_ptr_q] | out_ready);
        push_ok    = push_vld & ~occ_q[push_ptr];
        push_hit   = push_vld & occ_q[push_ptr];
        push_oh    = push_ok ? (8'(1) << push_ptr) : 8'h00;
        // Push wins a free slot that the preset also targets.
        fake_ok    = fake_set_vld ? (fake_set_mask & ~occ_q & ~push_oh) : 8'h00;
        fake_hit   = fake_set_vld & (|(fake_set_mask & (occ_q | push_oh)));

        occ_nxt    = occ_q;
        fake_nxt   = fake_q;
        if (retire) begin
            occ_nxt[rd_ptr_q]  = 1'b0;
            fake_nxt[rd_ptr_q] = 1'b0;
        end
        occ_nxt    = occ_nxt | push_oh | fake_ok;
        fake_nxt   = (fake_nxt & ~push_oh) | fake_ok;

        rd_ptr_nxt = rd_ptr_q + PTR_W'(retire);
        err_nxt    = err_q | push_hit | fake_hit;
    end

    // Registered view of the next head and occupancy summaries.
    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < 8; i++) begin
            cnt_nxt = cnt_nxt + CNT_W'(occ_nxt[i]);
        end
        vld_nxt   = occ_nxt[rd_ptr_nxt] & ~fake_nxt[rd_ptr_nxt];
        odata_nxt = (push_ok && (push_ptr == rd_ptr_nxt)) ? push_data : data_q[rd_ptr_nxt];
    end

    // Slot control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q       <= '0;
            fake_q      <= '0;
            rd_ptr_q    <= '0;
            err_q       <= 1'b0;
            out_vld     <= 1'b0;
            out_data    <= '0;
            occ_cnt     <= '0;
            que_empty   <= 1'b1;
            que_full    <= 1'b0;
        end else begin
            occ_q       <= occ_nxt;
            fake_q      <= fake_nxt;
            rd_ptr_q    <= rd_ptr_nxt;
            err_q       <= err_nxt;
            out_vld     <= vld_nxt;
            out_data    <= odata_nxt;
            occ_cnt     <= cnt_nxt;
            que_empty   <= (occ_nxt == 8'h00);
            que_full    <= (occ_nxt == 8'hFF);
        end
    end

    // Payload storage; intentionally not cleared by reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            data_q[push_ptr] <= push_data;
        end
    end

    assign resp_array  = occ_q;
    assign rd_ptr      = rd_ptr_q;
    assign err_collide = err_q;

endmodule
